// File: rtl/pio_gen2_pkg.sv
// Shared definitions for pio_gen2: register map, edge-type codes, synchroniser depth.
// PIO_GEN2_SYNC2_EN selects a two-flop input synchroniser; default is a single register.
package pio_gen2_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

`ifdef PIO_GEN2_SYNC2_EN
    localparam int unsigned SYNC_DEPTH = 2;
`else
    localparam int unsigned SYNC_DEPTH = 1;
`endif

    // Detection is enabled once the reset-zeroed pipeline has filled with real samples.
    localparam logic [1:0] PRIME_DONE = 2'(SYNC_DEPTH + 1);

endpackage

// File: rtl/pio_gen2_edge.sv
// Input synchroniser, previous-sample register, priming counter and edge detect.
// Depth follows PIO_GEN2_SYNC2_EN (two flops when defined, one otherwise).
module pio_gen2_edge
    import pio_gen2_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    input  logic [WIDTH-1:0] oe,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] detect
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [1:0]       prime_cnt;
    logic             primed;
    logic [WIDTH-1:0] edge_raw;

`ifdef PIO_GEN2_SYNC2_EN
    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= in_port;
            sync_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= in_port;
        end
    end
`endif

    // prev_q tracks s regardless of direction, so an output->input switch sees no edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            prime_cnt <= '0;
        end else begin
            prev_q <= sync_q;
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    assign primed = (prime_cnt == PRIME_DONE);
    assign s      = sync_q;

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_raw = sync_q & ~prev_q;
            EDGE_FALL: edge_raw = ~sync_q & prev_q;
            default:   edge_raw = sync_q ^ prev_q;
        endcase
    end

    assign detect = primed ? (edge_raw & ~oe) : '0;

endmodule

// File: rtl/pio_gen2.sv
// Parametrised Avalon-MM PIO: per-bit direction, set/clear output access, edge capture irq.
// Build option PIO_GEN2_SYNC2_EN selects a two-flop input synchroniser.
module pio_gen2
    import pio_gen2_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    parameter logic [WIDTH-1:0] DIR_RESET = '0,
    parameter int unsigned      EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr_strobe;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] detect;
    logic             unused_wd;

    assign wr_strobe = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    // Bits above WIDTH are intentionally discarded.
    assign unused_wd = ^writedata;

    pio_gen2_edge #(
        .WIDTH    (WIDTH),
        .EDGE_TYPE(EDGE_TYPE)
    ) u_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .in_port(in_port),
        .oe     (dir_q),
        .s      (s),
        .detect (detect)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= OUT_RESET;
            dir_q    <= DIR_RESET;
            mask_q   <= '0;
        end else if (wr_strobe) begin
            case (address)
                ADDR_DATA: data_out <= wd;
                ADDR_DIR:  dir_q    <= wd;
                ADDR_MASK: mask_q   <= wd;
                ADDR_SET:  data_out <= data_out | wd;
                ADDR_CLR:  data_out <= data_out & ~wd;
                default:   ;
            endcase
        end
    end

    assign cap_clr = (wr_strobe && (address == ADDR_EDGE)) ? wd : '0;

    // A new edge overrides a same-cycle write-1-to-clear on that bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= (cap_q & ~cap_clr) | detect;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = (dir_q & data_out) | (~dir_q & s);
            ADDR_DIR:  readdata[WIDTH-1:0] = dir_q;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata[WIDTH-1:0] = cap_q;
            default:   readdata = '0;
        endcase
    end

    assign out_port = data_out;
    assign oe       = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_gen2.sv
// Scoreboard bench for pio_gen2: driver queues expected values, negedge monitor compares.
// Latencies follow SYNC_DEPTH, so the bench runs with or without PIO_GEN2_SYNC2_EN.
module tb_pio_gen2;
    import pio_gen2_pkg::*;

    localparam int unsigned SD = SYNC_DEPTH;
    localparam int SEL_RD  = 0;
    localparam int SEL_OUT = 1;
    localparam int SEL_OE  = 2;
    localparam int SEL_IRQ = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    logic        chk_valid;
    string       nm_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    pio_gen2 #(
        .WIDTH    (8),
        .OUT_RESET(8'hA5),
        .DIR_RESET(8'hFF),
        .EDGE_TYPE(0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe        (oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: pops one expectation per sampled cycle.
    always @(negedge clk) begin
        string       nm;
        int          sel;
        logic [31:0] e;
        logic [31:0] act;
        if (chk_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got no expectation, required one");
            end else begin
                nm  = nm_q.pop_front();
                sel = sel_q.pop_front();
                e   = exp_q.pop_front();
                case (sel)
                    SEL_OUT: act = 32'(out_port);
                    SEL_OE:  act = 32'(oe);
                    SEL_IRQ: act = 32'(irq);
                    default: act = readdata;
                endcase
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic chk(input string nm, input int sel, input logic [2:0] a, input logic [31:0] e);
        nm_q.push_back(nm);
        sel_q.push_back(sel);
        exp_q.push_back(e);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        chk_valid  = 1'b1;
        @(negedge clk);
        #1;
        chk_valid  = 1'b0;
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'hFF;
        chk_valid  = 1'b0;
        repeat (2) tick();

        chk("rst_out_port", SEL_OUT, 3'd0, 32'hA5);
        chk("rst_oe",       SEL_OE,  3'd0, 32'hFF);
        chk("rst_irq",      SEL_IRQ, 3'd0, 32'h0);
        chk("rst_rd_data",  SEL_RD,  ADDR_DATA, 32'hA5);
        chk("rst_rd_set",   SEL_RD,  ADDR_SET,  32'h0);
        chk("rst_rd_rsvd6", SEL_RD,  3'd6,      32'h0);

        // Release with inputs high; pins become inputs on the first edge, inside priming.
        tick();
        reset_n = 1'b1;
        wr(ADDR_DIR, 32'h0);
        repeat (SD + 3) tick();
        chk("prime_no_capture", SEL_RD, ADDR_EDGE, 32'h0);
        chk("rd_sync_in",       SEL_RD, ADDR_DATA, 32'hFF);

        wr(ADDR_DATA, 32'h0F);
        wr(ADDR_SET,  32'h30);
        wr(ADDR_CLR,  32'h03);
        chk("set_clr_out", SEL_OUT, 3'd0, 32'h3C);
        wr(ADDR_DIR, 32'hF0);
        chk("rd_dir",   SEL_RD, ADDR_DIR,  32'hF0);
        chk("rd_mixed", SEL_RD, ADDR_DATA, 32'h3F);
        wr(ADDR_MASK, 32'h01);
        chk("rd_mask", SEL_RD, ADDR_MASK, 32'h01);
        wr(ADDR_DATA, 32'hFFFF_FF00);
        chk("wide_write", SEL_OUT, 3'd0, 32'h00);
        wr(ADDR_DIR, 32'h0);
        repeat (2) tick();
        chk("dir_change_no_edge", SEL_RD, ADDR_EDGE, 32'h0);

        in_port = 8'h00;
        repeat (SD + 3) tick();
        chk("fall_no_cap", SEL_RD, ADDR_EDGE, 32'h0);
        tick();
        in_port = 8'h01;
        for (int unsigned i = 0; i < SD; i++) begin
            tick();
            chk("irq_early", SEL_IRQ, 3'd0, 32'h0);
        end
        tick();
        chk("irq_latency", SEL_IRQ, 3'd0, 32'h1);
        chk("rise_cap",    SEL_RD,  ADDR_EDGE, 32'h01);

        // Clear write lands on the same edge that captures a fresh rising edge.
        in_port = 8'h00;
        repeat (SD + 3) tick();
        chk("cap_held", SEL_RD, ADDR_EDGE, 32'h01);
        tick();
        in_port = 8'h01;
        repeat (SD) tick();
        wr(ADDR_EDGE, 32'h01);
        chk("set_wins",     SEL_RD,  ADDR_EDGE, 32'h01);
        chk("set_wins_irq", SEL_IRQ, 3'd0,      32'h1);
        wr(ADDR_EDGE, 32'h01);
        chk("clear",     SEL_RD,  ADDR_EDGE, 32'h0);
        chk("clear_irq", SEL_IRQ, 3'd0,      32'h0);

        in_port = 8'h03;
        repeat (SD + 3) tick();
        chk("cap_unmasked", SEL_RD,  ADDR_EDGE, 32'h02);
        chk("irq_masked",   SEL_IRQ, 3'd0,      32'h0);
        wr(ADDR_EDGE, 32'hFF);
        chk("clear_all", SEL_RD, ADDR_EDGE, 32'h0);

        wr(ADDR_DIR, 32'h01);
        in_port = 8'h02;
        repeat (SD + 3) tick();
        in_port = 8'h03;
        repeat (SD + 3) tick();
        chk("oe_no_cap",   SEL_RD, ADDR_EDGE, 32'h0);
        chk("rd_mixed_oe", SEL_RD, ADDR_DATA, 32'h02);

        wr(ADDR_DIR,  32'h0);
        wr(ADDR_MASK, 32'hFF);
        in_port = 8'h07;
        repeat (SD + 3) tick();
        chk("pre_rst_cap", SEL_RD,  ADDR_EDGE, 32'h04);
        chk("pre_rst_irq", SEL_IRQ, 3'd0,      32'h1);

        // Reset asserted mid-cycle while a write is being presented.
        tick();
        address    = ADDR_DATA;
        writedata  = 32'h55;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1;
        reset_n = 1'b0;
        chk("async_rst_irq",  SEL_IRQ, 3'd0,      32'h0);
        chk("async_rst_out",  SEL_OUT, 3'd0,      32'hA5);
        chk("async_rst_oe",   SEL_OE,  3'd0,      32'hFF);
        chk("async_rst_cap",  SEL_RD,  ADDR_EDGE, 32'h0);
        chk("async_rst_mask", SEL_RD,  ADDR_MASK, 32'h0);
        reset_n = 1'b1;
        repeat (2) tick();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_gen2.md
Name: pio_gen2

Overview:
Parametrised general-purpose I/O port on the Avalon-MM slave bus, for system-level processor peripherals.
- Generalises the fixed 8-bit output-only PIO: width is configurable and each bit has its own direction.
- Input bits are synchronised, and selected edges on them are captured and can raise a maskable interrupt.
- Output set/clear registers allow bit manipulation without read-modify-write.

Parameters:
WIDTH, 8, number of I/O bits (1..32)
OUT_RESET, 0, reset value of the output data register (WIDTH bits)
DIR_RESET, 0, reset value of the direction register (1 = output)
EDGE_TYPE, 0, captured edge: 0 rising, 1 falling, 2 any

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  write strobe, active-low
writedata  in  32  write data; bits above WIDTH ignored
readdata  out  32  read data, zero-extended above WIDTH
in_port  in  WIDTH  external input pins, asynchronous to clk
out_port  out  WIDTH  output data register
oe  out  WIDTH  per-bit output enable (direction register)
irq  out  1  interrupt request, active-high

Behaviour:
- Single clock domain (clk). reset_n asserts asynchronously and clears/sets all state immediately.
- Reset values:
  - out_port = OUT_RESET, oe = DIR_RESET.
  - irq_mask = 0, edge_capture = 0, so irq = 0.
  - Sync stages and previous-sample register = 0; priming counter = 0.
- wr_strobe = chipselect & ~write_n. Writes commit on the rising clk edge.
- Reads are zero-wait-state and combinational from registers. readdata depends only on address, independent of chipselect.
- Register map:
  - 0 data: write loads data_out; read returns per bit oe ? data_out : synced input.
  - 1 direction: R/W, 1 = output.
  - 2 irq_mask: R/W.
  - 3 edge_capture: read returns captured bits; write 1 clears that bit, write 0 has no effect.
  - 4 outset: write ORs writedata into data_out; reads 0.
  - 5 outclear: write ANDs data_out with ~writedata; reads 0.
  - 6, 7: reserved; writes ignored, reads 0.
- Input path: in_port passes through the synchroniser to give s. Register p holds s delayed one cycle.
- Edge detect per bit:
  - rising = s & ~p; falling = ~s & p; any = s ^ p.
  - Detection is gated by ~oe, so output bits never capture.
- Priming: after reset, a 2-bit counter suppresses detection until it reaches SYNC_DEPTH+1 cycles. This prevents false edges from the reset-zeroed pipeline. The counter then saturates.
- edge_capture bit sets on a detected edge and holds until cleared. If a clear write and a new edge hit the same bit in the same cycle, set wins.
- irq = |(edge_capture & irq_mask), driven directly from flops with no extra register stage.
  - An edge appearing in s at cycle n sets capture at n+1, and irq is visible at n+1.
- Changing direction from output to input does not itself create an edge: p is updated every cycle regardless of oe.

Optional Feature:
Macro PIO_GEN2_SYNC2_EN.
- Defined: SYNC_DEPTH = 2 (two-flop metastability synchroniser). Pin-to-s latency is 2 clk; pin-to-irq is 3 clk.
- Undefined: SYNC_DEPTH = 1 (single register, for pins already synchronous to clk). Pin-to-irq is 2 clk. Priming adjusts accordingly.

Decomposition:
- Package pio_gen2_pkg:
  - Register address localparams: ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_SET=4, ADDR_CLR=5.
  - Edge type constants: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module pio_gen2_edge: per-WIDTH vector containing synchroniser, previous-sample register, priming counter and edge-detect logic. Outputs s and the detect vector. The top level holds the bus registers, capture, irq and read mux.

Test Plan:
1. Reset with OUT_RESET=8'hA5, DIR_RESET=8'hFF -> out_port=A5, oe=FF, irq=0. Read addr 0 -> 0xA5. Reads of addr 4/6 -> 0.
2. Write 0x0F to addr 0, 0x30 to addr 4, 0x03 to addr 5 -> out_port=0x3C after the third write. Bits above WIDTH (writedata=0xFFFF_FF00 to addr 0) -> out_port=0x00.
3. DIR=0, EDGE_TYPE=0, mask=0x01, in_port[0] 0->1 -> edge_capture=0x01 and irq=1 exactly 3 clk later (SYNC2_EN). Falling edge -> no capture.
4. Write 0x01 to addr 3 in the same cycle a new rising edge on bit 0 is detected -> bit stays 1. Clear with no edge -> bit 0, irq=0.
5. Hold in_port=0xFF through reset release -> no capture during priming, edge_capture=0. An output bit (oe=1) toggling on in_port -> no capture.
6. Assert reset_n low mid-write/capture -> all registers return immediately (asynchronously) to reset values; irq drops in the same cycle.
